// File: rtl/pwm_sample_player.sv
// Playback stage after the PWM-buffer FIFO: fetches one sample per repeat group
// and renders it as a registered single-bit PWM waveform, counting underruns.
module pwm_sample_player #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          SIGNED_IN = 1'b1,
    parameter int unsigned REPEAT    = 1
) (
    input  logic             M100CLK,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             empty,
    output logic             request,
    output logic             pwm_out,
    output logic             frame_strobe,
    output logic [15:0]      underrun_count
);

    localparam logic [WIDTH-1:0] MID        = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [WIDTH-1:0] CNT_CAP    = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] CNT_DECIDE = {{(WIDTH-2){1'b1}}, 2'b00};
    localparam logic [WIDTH-1:0] SIGN_MASK  = SIGNED_IN ? MID : '0;
    localparam logic [7:0]       REP_LAST   = 8'(REPEAT - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [7:0]       rep_cnt_q, rep_cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] next_duty_q, next_duty_d;
    logic             fetch_q, fetch_d;
    logic             underrun_q, underrun_d;
    logic             request_q, request_d;
    logic             pwm_out_q, pwm_out_d;
    logic             frame_strobe_q, frame_strobe_d;
    logic [15:0]      underrun_count_q, underrun_count_d;
    logic             last_rep;

    always_comb begin
        state_d          = state_q;
        pwm_cnt_d        = pwm_cnt_q;
        rep_cnt_d        = rep_cnt_q;
        duty_d           = duty_q;
        next_duty_d      = next_duty_q;
        fetch_d          = fetch_q;
        underrun_d       = underrun_q;
        request_d        = 1'b0;
        pwm_out_d        = 1'b0;
        frame_strobe_d   = 1'b0;
        underrun_count_d = underrun_count_q;
        last_rep         = (rep_cnt_q == REP_LAST);

        if (state_q == RUN && enable) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
            pwm_out_d = (pwm_cnt_q < duty_q);

            // Empty is judged one clock ahead so request leaves a flop and is
            // high exactly while pwm_cnt sits at 2**WIDTH-3.
            if (last_rep && pwm_cnt_q == CNT_DECIDE) begin
                if (!empty) begin
                    request_d = 1'b1;
                    fetch_d   = 1'b1;
                end else begin
                    underrun_d = 1'b1;
                end
            end

            if (pwm_cnt_q == CNT_CAP) begin
                if (fetch_q) begin
                    next_duty_d = sample_in ^ SIGN_MASK;
                end else if (underrun_q) begin
                    next_duty_d = MID;
                end
            end

            if (pwm_cnt_q == CNT_MAX) begin
                fetch_d    = 1'b0;
                underrun_d = 1'b0;
                if (underrun_q && underrun_count_q != 16'hFFFF) begin
                    underrun_count_d = underrun_count_q + 1'b1;
                end
                if (last_rep) begin
                    rep_cnt_d      = '0;
                    duty_d         = next_duty_q;
                    frame_strobe_d = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
        end else begin
            // Idle, or leaving RUN: any fetch in flight is dropped here.
            state_d     = (state_q == IDLE && enable) ? RUN : IDLE;
            pwm_cnt_d   = '0;
            rep_cnt_d   = '0;
            duty_d      = MID;
            next_duty_d = MID;
            fetch_d     = 1'b0;
            underrun_d  = 1'b0;
        end
    end

    always_ff @(posedge M100CLK) begin
        if (reset) begin
            state_q          <= IDLE;
            pwm_cnt_q        <= '0;
            rep_cnt_q        <= '0;
            duty_q           <= MID;
            next_duty_q      <= MID;
            fetch_q          <= 1'b0;
            underrun_q       <= 1'b0;
            request_q        <= 1'b0;
            pwm_out_q        <= 1'b0;
            frame_strobe_q   <= 1'b0;
            underrun_count_q <= '0;
        end else begin
            state_q          <= state_d;
            pwm_cnt_q        <= pwm_cnt_d;
            rep_cnt_q        <= rep_cnt_d;
            duty_q           <= duty_d;
            next_duty_q      <= next_duty_d;
            fetch_q          <= fetch_d;
            underrun_q       <= underrun_d;
            request_q        <= request_d;
            pwm_out_q        <= pwm_out_d;
            frame_strobe_q   <= frame_strobe_d;
            underrun_count_q <= underrun_count_d;
        end
    end

    assign request        = request_q;
    assign pwm_out        = pwm_out_q;
    assign frame_strobe   = frame_strobe_q;
    assign underrun_count = underrun_count_q;

endmodule

// File: tb/tb_pwm_sample_player.sv
// Directed bench for pwm_sample_player: one REPEAT=1 instance with a small FIFO
// model, plus a REPEAT=4 instance fed from a never-empty source.
module tb_pwm_sample_player;

    logic        clk;
    logic        reset, enable, empty;
    logic [7:0]  sample_in;
    logic        request, pwm_out, frame_strobe;
    logic [15:0] underrun_count;

    logic        rst4, en4, empty4;
    logic [7:0]  sample4;
    logic        req4, pwm4, strobe4;
    logic [15:0] ucount4;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:7];
    int         n = 0;
    int         rd, viol;
    logic       req_prev;
    logic [7:0] tbl4 [0:2];
    int         rd4;
    logic       req_prev4;

    pwm_sample_player #(.WIDTH(8), .SIGNED_IN(1'b1), .REPEAT(1)) dut (
        .M100CLK(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
        .empty(empty), .request(request), .pwm_out(pwm_out),
        .frame_strobe(frame_strobe), .underrun_count(underrun_count)
    );

    pwm_sample_player #(.WIDTH(8), .SIGNED_IN(1'b1), .REPEAT(4)) dut4 (
        .M100CLK(clk), .reset(rst4), .enable(en4), .sample_in(sample4),
        .empty(empty4), .request(req4), .pwm_out(pwm4),
        .frame_strobe(strobe4), .underrun_count(ucount4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO model: data appears one clock after each request pulse.
    initial begin
        rd = 0; viol = 0; req_prev = 1'b0; sample_in = 8'h00; empty = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                rd = 0;
                req_prev = 1'b0;
            end else begin
                if (request && empty) viol++;
                if (req_prev && rd < n) begin
                    sample_in = mem[rd];
                    rd++;
                end
                req_prev = request;
            end
            empty = (rd >= n);
        end
    end

    initial begin
        rd4 = 0; req_prev4 = 1'b0; sample4 = 8'h00; empty4 = 1'b0;
        tbl4[0] = 8'h20; tbl4[1] = 8'hE0; tbl4[2] = 8'h60;
        forever begin
            @(negedge clk);
            if (rst4) begin
                rd4 = 0;
                req_prev4 = 1'b0;
            end else begin
                if (req_prev4) begin
                    sample4 = tbl4[rd4 % 3];
                    rd4++;
                end
                req_prev4 = req4;
            end
        end
    end

    task automatic start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int cnt);
        reset  = 1'b1;
        enable = 1'b0;
        mem[0] = a; mem[1] = b; mem[2] = c;
        n = cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic wait_strobe(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!frame_strobe && waited < 3000);
    endtask

    task automatic measure_frame(output int high, output int reqpos, output int reqcnt);
        high = 0; reqpos = -1; reqcnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_out) high++;
            if (request) begin
                reqcnt++;
                reqpos = (i + 1) % 256;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks += 4;
            if (request !== 1'b0) begin failures++; $display("FAIL reset_request cyc=%0d got=%b exp=0", i, request); end
            if (pwm_out !== 1'b0) begin failures++; $display("FAIL reset_pwm cyc=%0d got=%b exp=0", i, pwm_out); end
            if (frame_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe cyc=%0d got=%b exp=0", i, frame_strobe); end
            if (underrun_count !== 16'h0) begin failures++; $display("FAIL reset_count cyc=%0d got=%h exp=0", i, underrun_count); end
        end
        enable = 1'b0;
    endtask

    task automatic test_signed_map;
        int w, h, rp, rc;
        int exp_h [3];
        exp_h[0] = 128; exp_h[1] = 255; exp_h[2] = 0;
        start(8'h00, 8'h7F, 8'h80, 3);
        wait_strobe(w);
        checks++;
        if (w !== 257) begin failures++; $display("FAIL map_first_strobe got=%0d exp=257", w); end
        for (int k = 0; k < 3; k++) begin
            measure_frame(h, rp, rc);
            checks += 2;
            if (h !== exp_h[k]) begin failures++; $display("FAIL map_duty frame=%0d got=%0d exp=%0d", k + 1, h, exp_h[k]); end
            if (frame_strobe !== 1'b1) begin failures++; $display("FAIL map_strobe frame=%0d got=%b exp=1", k + 1, frame_strobe); end
        end
        checks++;
        if (underrun_count !== 16'd1) begin failures++; $display("FAIL map_underrun got=%0d exp=1", underrun_count); end
        measure_frame(h, rp, rc);
        checks += 2;
        if (h !== 128) begin failures++; $display("FAIL map_underrun_duty got=%0d exp=128", h); end
        if (rc !== 0) begin failures++; $display("FAIL map_no_request got=%0d exp=0", rc); end
    endtask

    task automatic test_handshake;
        int w, h, rp, rc;
        start(8'h40, 8'hC0, 8'h00, 2);
        wait_strobe(w);
        measure_frame(h, rp, rc);
        checks += 5;
        if (h !== 192) begin failures++; $display("FAIL hs_duty1 got=%0d exp=192", h); end
        if (rc !== 1) begin failures++; $display("FAIL hs_req_width got=%0d exp=1", rc); end
        if (rp !== 253) begin failures++; $display("FAIL hs_req_pos got=%0d exp=253", rp); end
        if (frame_strobe !== 1'b1) begin failures++; $display("FAIL hs_strobe got=%b exp=1", frame_strobe); end
        if (underrun_count !== 16'd0) begin failures++; $display("FAIL hs_count got=%0d exp=0", underrun_count); end
        measure_frame(h, rp, rc);
        checks += 2;
        if (h !== 64) begin failures++; $display("FAIL hs_duty2 got=%0d exp=64", h); end
        if (rc !== 0) begin failures++; $display("FAIL hs_req_empty got=%0d exp=0", rc); end
    endtask

    task automatic test_underrun;
        int w, h, rp, rc;
        start(8'h00, 8'h00, 8'h00, 0);
        wait_strobe(w);
        checks++;
        if (underrun_count !== 16'd1) begin failures++; $display("FAIL ur_count1 got=%0d exp=1", underrun_count); end
        measure_frame(h, rp, rc);
        checks += 3;
        if (h !== 128) begin failures++; $display("FAIL ur_duty got=%0d exp=128", h); end
        if (rc !== 0) begin failures++; $display("FAIL ur_request got=%0d exp=0", rc); end
        if (underrun_count !== 16'd2) begin failures++; $display("FAIL ur_count2 got=%0d exp=2", underrun_count); end
        force dut.underrun_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.underrun_count_q;
        wait_strobe(w);
        checks++;
        if (underrun_count !== 16'hFFFF) begin failures++; $display("FAIL ur_sat_reach got=%h exp=ffff", underrun_count); end
        wait_strobe(w);
        checks += 2;
        if (w !== 256) begin failures++; $display("FAIL ur_frame_len got=%0d exp=256", w); end
        if (underrun_count !== 16'hFFFF) begin failures++; $display("FAIL ur_sat_hold got=%h exp=ffff", underrun_count); end
        enable = 1'b0;
    endtask

    task automatic test_repeat4;
        int w, rq, rp, st, prev_abs;
        int hi [4];
        int exp_g [2];
        exp_g[0] = 160; exp_g[1] = 96;
        prev_abs = 0;
        rst4 = 1'b1; en4 = 1'b0;
        repeat (3) @(negedge clk);
        rst4 = 1'b0;
        @(negedge clk);
        en4 = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!strobe4 && w < 3000);
        checks++;
        if (w !== 1025) begin failures++; $display("FAIL r4_first_strobe got=%0d exp=1025", w); end
        for (int g = 0; g < 2; g++) begin
            for (int f = 0; f < 4; f++) hi[f] = 0;
            rq = 0; rp = -1; st = 0;
            for (int i = 0; i < 1024; i++) begin
                @(negedge clk);
                if (pwm4) hi[i / 256]++;
                if (req4) begin rq++; rp = i + 1; end
                if (strobe4 && i < 1023) st++;
            end
            for (int f = 0; f < 4; f++) begin
                checks++;
                if (hi[f] !== exp_g[g]) begin failures++; $display("FAIL r4_duty grp=%0d frame=%0d got=%0d exp=%0d", g, f, hi[f], exp_g[g]); end
            end
            checks += 4;
            if (rq !== 1) begin failures++; $display("FAIL r4_req_count grp=%0d got=%0d exp=1", g, rq); end
            if (rp !== 1021) begin failures++; $display("FAIL r4_req_pos grp=%0d got=%0d exp=1021", g, rp); end
            if (st !== 0) begin failures++; $display("FAIL r4_mid_strobes grp=%0d got=%0d exp=0", g, st); end
            if (strobe4 !== 1'b1) begin failures++; $display("FAIL r4_group_strobe grp=%0d got=%b exp=1", g, strobe4); end
            if (g == 1) begin
                checks++;
                if ((1024 + rp) - prev_abs !== 1024) begin failures++; $display("FAIL r4_spacing got=%0d exp=1024", (1024 + rp) - prev_abs); end
            end
            prev_abs = rp;
        end
        en4 = 1'b0;
        rst4 = 1'b1;
    endtask

    task automatic test_abort;
        int w, h, rp, rc, bad;
        start(8'h7F, 8'h50, 8'h60, 3);
        wait_strobe(w);
        rc = 0;
        for (int i = 0; i < 254; i++) begin
            @(negedge clk);
            if (request) rc++;
        end
        checks += 2;
        if (rc !== 1) begin failures++; $display("FAIL ab_req_before got=%0d exp=1", rc); end
        if (pwm_out !== 1'b1) begin failures++; $display("FAIL ab_pwm_before got=%b exp=1", pwm_out); end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (pwm_out !== 1'b0) begin failures++; $display("FAIL ab_pwm_after got=%b exp=0", pwm_out); end
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (request || pwm_out || frame_strobe) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL ab_idle_activity got=%0d exp=0", bad); end
        enable = 1'b1;
        @(negedge clk);
        measure_frame(h, rp, rc);
        checks += 3;
        if (h !== 128) begin failures++; $display("FAIL ab_reenable_duty got=%0d exp=128", h); end
        if (rc !== 1) begin failures++; $display("FAIL ab_reenable_req got=%0d exp=1", rc); end
        if (frame_strobe !== 1'b1) begin failures++; $display("FAIL ab_reenable_strobe got=%b exp=1", frame_strobe); end
        measure_frame(h, rp, rc);
        checks++;
        if (h !== 224) begin failures++; $display("FAIL ab_discard got=%0d exp=224", h); end
        repeat (50) @(negedge clk);
        checks += 2;
        if (pwm_out !== 1'b1) begin failures++; $display("FAIL ab_midframe_pwm got=%b exp=1", pwm_out); end
        if (underrun_count !== 16'd1) begin failures++; $display("FAIL ab_midframe_count got=%0d exp=1", underrun_count); end
        reset = 1'b1;
        @(negedge clk);
        checks += 3;
        if (pwm_out !== 1'b0) begin failures++; $display("FAIL ab_reset_pwm got=%b exp=0", pwm_out); end
        if (request !== 1'b0) begin failures++; $display("FAIL ab_reset_req got=%b exp=0", request); end
        if (underrun_count !== 16'd0) begin failures++; $display("FAIL ab_reset_count got=%0d exp=0", underrun_count); end
        reset = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1;
        rst4 = 1'b1; en4 = 1'b0;
        test_reset();
        test_signed_map();
        test_handshake();
        test_underrun();
        test_repeat4();
        test_abort();
        checks++;
        if (viol !== 0) begin failures++; $display("FAIL request_while_empty got=%0d exp=0", viol); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
